// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } fetch_state_t;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a
// time, hands fetched words to decode and squashes responses of killed
// requests after a redirect.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned           WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_i,
    input  logic [WORD_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [WORD_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [WORD_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    output logic [WORD_WIDTH-1:0] instr_o,
    output logic [WORD_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i,
    output logic                  misalign_o,
    output logic [WORD_WIDTH-1:0] fetch_cnt_o
);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] target_aligned;
    logic                  capture_c;
    logic                  accept_c;

    // Redirect targets are forced onto a word boundary.
    assign target_aligned = {redirect_pc_i[WORD_WIDTH-1:2], 2'b00};
    assign imem_addr_o    = pc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a redirect always wins over sequential progress.
    always_comb begin
        state_next = state;
        case (state)
            S_REQ: begin
                if (imem_gnt_i) begin
                    state_next = redirect_i ? S_FLUSH : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_next = redirect_i ? S_REQ : S_HOLD;
                end else if (redirect_i) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (imem_rvalid_i) begin
                    state_next = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_i || instr_ready_i) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    // State-decoded handshake outputs and datapath strobes.
    always_comb begin
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;
        capture_c     = 1'b0;
        accept_c      = 1'b0;
        case (state)
            S_REQ:  imem_req_o = 1'b1;
            S_WAIT: capture_c  = imem_rvalid_i && !redirect_i;
            S_HOLD: begin
                instr_valid_o = 1'b1;
                accept_c      = instr_ready_i && !redirect_i;
            end
            default: ;
        endcase
    end

    // PC, instruction buffer, misalign flag and retired-fetch counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr_o     <= '0;
            instr_pc_o  <= '0;
            misalign_o  <= 1'b0;
            fetch_cnt_o <= '0;
        end else begin
            misalign_o <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
            if (redirect_i) begin
                pc <= target_aligned;
            end else if (accept_c) begin
                pc <= pc + WORD_WIDTH'(PC_STEP);
            end
            if (capture_c) begin
                instr_o    <= imem_rdata_i;
                instr_pc_o <= pc;
            end
            if (accept_c) begin
                fetch_cnt_o <= fetch_cnt_o + WORD_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch around the program counter: holds the architectural PC, issues one request at a time to instruction memory and presents the fetched word to decode with a valid/ready handshake.
- Applies redirects (jal/jalr/taken branch targets computed downstream) with priority over sequential advance, and discards responses of killed requests.
- Sits between the PC datapath, instruction memory and the decoder; also counts retired fetches for debug.

Parameters:
- WORD_WIDTH, 32, width of PC, address, instruction and counter.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- redirect_i  input  1  one-cycle pulse: replace PC with redirect_pc_i.
- redirect_pc_i  input  WORD_WIDTH  redirect target.
- imem_req_o  output  1  fetch request, held until granted.
- imem_addr_o  output  WORD_WIDTH  fetch address (= pc).
- imem_gnt_i  input  1  request accepted this cycle.
- imem_rvalid_i  input  1  response data valid (>=1 cycle after gnt).
- imem_rdata_i  input  WORD_WIDTH  response instruction.
- instr_valid_o  output  1  instruction available to decode.
- instr_o  output  WORD_WIDTH  registered instruction.
- instr_pc_o  output  WORD_WIDTH  PC of instr_o.
- instr_ready_i  input  1  decode accepts instr_o this cycle.
- misalign_o  output  1  one-cycle pulse: redirect target had nonzero bits [1:0].
- fetch_cnt_o  output  WORD_WIDTH  count of accepted instructions.

Behaviour:
- Reset (sync, rst high at posedge): pc=RESET_PC, state=S_REQ, instr_o=0, instr_pc_o=0, instr_valid_o=0, misalign_o=0, fetch_cnt_o=0. imem_req_o is combinational from state, so it is 1 in the first cycle after rst falls. Instruction memory shares rst; no pre-reset response may arrive afterwards. Reset mid-operation aborts everything with no residual output.
- States: S_REQ, S_WAIT, S_HOLD, S_FLUSH. imem_req_o=1 only in S_REQ; imem_addr_o=pc always; instr_valid_o=1 only in S_HOLD.
- S_REQ: gnt & !redirect -> S_WAIT. gnt & redirect -> pc<=target, S_FLUSH. !gnt & redirect -> pc<=target, stay S_REQ (address may change before grant; imem tolerates this).
- S_WAIT: rvalid & !redirect -> instr_o<=rdata, instr_pc_o<=pc, S_HOLD. redirect (with or without rvalid) -> pc<=target; next state S_REQ if rvalid this cycle (data dropped), else S_FLUSH.
- S_FLUSH: wait for killed response; rvalid -> data dropped, S_REQ. A further redirect here updates pc and stays in S_FLUSH (or goes to S_REQ if rvalid is also high).
- S_HOLD: redirect -> instruction dropped (not counted), pc<=target, S_REQ; redirect overrides a simultaneous instr_ready_i. Else instr_ready_i -> pc<=pc+4, fetch_cnt_o+1, S_REQ. Else hold with all outputs stable.
- Target alignment: pc<={redirect_pc_i[W-1:2],2'b00}. misalign_o=1 in the cycle after a redirect with nonzero [1:0].
- Arithmetic: pc+4 and fetch_cnt_o are modulo 2^WORD_WIDTH (0xFFFF_FFFC+4 -> 0; counter wraps to 0).
- Throughput: at most one outstanding request. Minimum 3 cycles per instruction (REQ, WAIT, HOLD) with gnt in the same cycle and rvalid the next cycle.

Decomposition:
- Package fetch_pkg: state enum fetch_state_t {S_REQ, S_WAIT, S_HOLD, S_FLUSH}; localparam PC_STEP=4.
- No sub-module required. The FSM, PC register and counter live in one module.

Test Plan:
- Reset, gnt tied 1, rvalid one cycle after gnt, ready=1, rdata=addr^32'hA5A5_0000 -> addresses 0,4,8 issued; instr_pc_o 0,4,8 each with matching instr_o; fetch_cnt_o=3 after third accept.
- Hold: ready=0 for 5 cycles in S_HOLD at pc=8 -> instr_valid_o, instr_o and instr_pc_o stable, imem_req_o=0; ready=1 -> next request to 0xC.
- Redirect in S_WAIT to 0x100, rvalid 2 cycles later with 0xDEAD_BEEF -> word dropped, instr_valid_o stays 0, next imem_addr_o=0x100, counter unchanged.
- Redirect and instr_ready_i in the same S_HOLD cycle, target 0x40 -> instruction not counted, next request at 0x40.
- Redirect target 0x203 -> misalign_o pulses 1 cycle, fetch address 0x200; RESET_PC=0xFFFF_FFFC, ready=1 -> second address 0x0.
- Assert rst for 1 cycle while in S_WAIT -> all outputs 0, pc=RESET_PC, imem_req_o=1 on the following cycle.
